icache_nway: RTL and testbench

- Parametrised set-associative instruction cache: successor of the fixed 2-set/2-way icache.
- Sits between the fetch stage and the memory arbiter.
- Adds over the previous generation: configurable sets/ways/line width, registered 1-cycle hit response, per-set true-LRU, valid/ready memory request handshake, whole-cache flush, saturating hit/miss counters.

---
 rtl/icache_nway.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_icache_nway.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// icache_nway: parametrised set-associative instruction cache.
// Registered 1-cycle hit response, per-set true-LRU ages, single outstanding
// line refill over a valid/ready request channel, whole-cache flush (deferred
// while a refill is in flight) and saturating hit/miss counters.
module icache_nway #(
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [ADDR_WIDTH-1:0]                       req_addr,
    output logic                                        rsp_valid,
    output logic [LINE_WIDTH-1:0]                       rsp_data,
    output logic                                        rsp_bus_error,
    input  logic                                        flush_req,
    output logic                                        flush_done,
    output logic                                        mem_req_valid,
    input  logic                                        mem_req_ready,
    output logic [ADDR_WIDTH-$clog2(LINE_WIDTH/8)-1:0]  mem_req_addr,
    input  logic                                        mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]                       mem_rsp_data,
    input  logic                                        mem_rsp_bus_error,
    output logic [CNT_WIDTH-1:0]                        hit_count,
    output logic [CNT_WIDTH-1:0]                        miss_count
);

    localparam int OFF     = $clog2(LINE_WIDTH / 8);
    localparam int IDX     = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_WIDTH - OFF - IDX;
    localparam int LADDR_W = ADDR_WIDTH - OFF;
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int AGE_W   = WAY_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISS_REQ  = 2'd1,
        ST_MISS_WAIT = 2'd2
    } state_e;

    typedef logic [NUM_WAYS-1:0][AGE_W-1:0] ages_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Reset ordering: way w starts with age w (way 0 most recent).
    function automatic ages_t lru_init();
        ages_t res;
        for (int w = 0; w < NUM_WAYS; w++) begin
            res[w] = AGE_W'(w);
        end
        return res;
    endfunction

    // True-LRU touch: accessed way goes to age 0, younger ways age by one.
    function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] way);
        ages_t               res;
        logic [AGE_W-1:0]    acc;
        acc = ages[way];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w == int'(way)) begin
                res[w] = {AGE_W{1'b0}};
            end else if (ages[w] < acc) begin
                res[w] = ages[w] + AGE_W'(1);
            end else begin
                res[w] = ages[w];
            end
        end
        return res;
    endfunction

    // Victim: lowest-index invalid way, otherwise the oldest way.
    function automatic logic [WAY_W-1:0] pick_victim(input logic [NUM_WAYS-1:0] valid,
                                                     input ages_t ages);
        logic [WAY_W-1:0] inv_way;
        logic [WAY_W-1:0] old_way;
        logic             any_inv;
        inv_way = {WAY_W{1'b0}};
        old_way = {WAY_W{1'b0}};
        any_inv = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                inv_way = WAY_W'(w);
                any_inv = 1'b1;
            end else begin
                inv_way = inv_way;
            end
            if (ages[w] == AGE_W'(NUM_WAYS - 1)) begin
                old_way = WAY_W'(w);
            end else begin
                old_way = old_way;
            end
        end
        return any_inv ? inv_way : old_way;
    endfunction

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [LINE_WIDTH-1:0] data_r  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]      tag_r   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_r [NUM_SETS];
    ages_t                 age_r   [NUM_SETS];

    state_e                state_r;
    state_e                state_next_s;
    logic                  flush_pending_r;
    logic [IDX-1:0]        miss_idx_r;
    logic [TAG_W-1:0]      miss_tag_r;
    logic [WAY_W-1:0]      victim_r;

    logic                  rsp_valid_r;
    logic [LINE_WIDTH-1:0] rsp_data_r;
    logic                  rsp_bus_error_r;
    logic                  flush_done_r;
    logic                  mem_req_valid_r;
    logic [LADDR_W-1:0]    mem_req_addr_r;
    logic [CNT_WIDTH-1:0]  hit_cnt_r;
    logic [CNT_WIDTH-1:0]  miss_cnt_r;

    logic [IDX-1:0]        req_idx_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [LINE_WIDTH-1:0] hit_data_s;
    logic                  req_ready_s;
    logic                  accept_s;
    logic                  fill_done_s;
    logic                  fill_ok_s;
    logic                  flush_now_s;
    logic                  unused_offset_s;

    assign req_idx_s       = req_addr[OFF+IDX-1:OFF];
    assign req_tag_s       = req_addr[ADDR_WIDTH-1:OFF+IDX];
    assign unused_offset_s = ^req_addr[OFF-1:0];

    assign req_ready_s = (state_r == ST_IDLE) && !flush_req && !flush_pending_r;
    assign accept_s    = req_valid && req_ready_s;
    assign fill_done_s = (state_r == ST_MISS_WAIT) && mem_rsp_valid;
    assign fill_ok_s   = fill_done_s && !mem_rsp_bus_error;
    // A flush lands either directly in IDLE or at the edge that leaves MISS_WAIT.
    assign flush_now_s = ((state_r == ST_IDLE) && flush_req) ||
                         (fill_done_s && (flush_pending_r || flush_req));

    // Tag compare of the addressed set against all ways.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = {WAY_W{1'b0}};
        hit_data_s = {LINE_WIDTH{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) begin
                hit_s      = 1'b1;
                hit_way_s  = WAY_W'(w);
                hit_data_s = data_r[req_idx_s][w];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !hit_s) begin
                    state_next_s = ST_MISS_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MISS_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_MISS_WAIT;
                end else begin
                    state_next_s = ST_MISS_REQ;
                end
            end
            ST_MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_MISS_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Miss context: set index, tag and chosen victim way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss_idx_r <= {IDX{1'b0}};
            miss_tag_r <= {TAG_W{1'b0}};
            victim_r   <= {WAY_W{1'b0}};
        end else if (accept_s && !hit_s) begin
            miss_idx_r <= req_idx_s;
            miss_tag_r <= req_tag_s;
            victim_r   <= pick_victim(valid_r[req_idx_s], age_r[req_idx_s]);
        end
    end

    // Valid bits and LRU ages; flush clears valid after any same-edge fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= {NUM_WAYS{1'b0}};
                age_r[s]   <= lru_init();
            end
        end else begin
            if (accept_s && hit_s) begin
                age_r[req_idx_s] <= lru_touch(age_r[req_idx_s], hit_way_s);
            end else if (fill_ok_s) begin
                age_r[miss_idx_r] <= lru_touch(age_r[miss_idx_r], victim_r);
            end
            if (flush_now_s) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_r[s] <= {NUM_WAYS{1'b0}};
                end
            end else if (fill_ok_s) begin
                valid_r[miss_idx_r][victim_r] <= 1'b1;
            end
        end
    end

    // Line data and tags, written only by a successful refill.
    always_ff @(posedge clock) begin
        if (fill_ok_s) begin
            data_r[miss_idx_r][victim_r] <= mem_rsp_data;
            tag_r[miss_idx_r][victim_r]  <= miss_tag_r;
        end
    end

    // Fetch response: hit data from the arrays or the refill beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid_r     <= 1'b0;
            rsp_data_r      <= {LINE_WIDTH{1'b0}};
            rsp_bus_error_r <= 1'b0;
        end else if (accept_s && hit_s) begin
            rsp_valid_r     <= 1'b1;
            rsp_data_r      <= hit_data_s;
            rsp_bus_error_r <= 1'b0;
        end else if (fill_done_s) begin
            rsp_valid_r     <= 1'b1;
            rsp_data_r      <= mem_rsp_data;
            rsp_bus_error_r <= mem_rsp_bus_error;
        end else begin
            rsp_valid_r     <= 1'b0;
        end
    end

    // Refill request channel; address held until the handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {LADDR_W{1'b0}};
        end else if (accept_s && !hit_s) begin
            mem_req_valid_r <= 1'b1;
            mem_req_addr_r  <= req_addr[ADDR_WIDTH-1:OFF];
        end else if (mem_req_valid_r && mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
        end
    end

    // Flush bookkeeping: remember flushes seen mid-refill, pulse done when applied.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
        end else begin
            flush_done_r <= flush_now_s;
            if (fill_done_s) begin
                flush_pending_r <= 1'b0;
            end else if ((state_r != ST_IDLE) && flush_req) begin
                flush_pending_r <= 1'b1;
            end
        end
    end

    // Saturating hit/miss counters for accepted requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_r  <= {CNT_WIDTH{1'b0}};
            miss_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            if (hit_s && (hit_cnt_r != {CNT_WIDTH{1'b1}})) begin
                hit_cnt_r <= hit_cnt_r + CNT_WIDTH'(1);
            end else if (!hit_s && (miss_cnt_r != {CNT_WIDTH{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign req_ready     = req_ready_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_bus_error = rsp_bus_error_r;
    assign flush_done    = flush_done_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign hit_count     = hit_cnt_r;
    assign miss_count    = miss_cnt_r;

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway at default parameters: a transaction-level cache
// model (recency timestamps for LRU) compared against the DUT every cycle,
// plus directed scenarios with literal expectations.
module tb_icache_nway;

    localparam int NS = 4;
    localparam int NW = 2;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [19:0]  req_addr;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_bus_error;
    logic         flush_req;
    logic         flush_done;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [15:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic         mem_rsp_bus_error;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    icache_nway dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_bus_error(rsp_bus_error),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_bus_error(mem_rsp_bus_error),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_valid [NS][NW];
    logic [15:0]  m_line  [NS][NW];
    logic [127:0] m_data  [NS][NW];
    longint       m_use   [NS][NW];
    longint       m_stamp;
    int           m_phase;      // 0 idle, 1 request outstanding, 2 awaiting data
    bit           m_pend;
    logic [15:0]  m_mline;
    int           m_victim;
    logic         e_rsp_valid, e_rsp_err, e_mreq_valid, e_flush_done;
    logic [127:0] e_rsp_data;
    logic [15:0]  e_mreq_addr, e_hit, e_miss;
    logic [15:0]  t_line;
    int           t_set, t_hw;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_pend = 1'b0; m_stamp = 0;
            e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_rsp_data = '0;
            e_mreq_valid = 1'b0; e_mreq_addr = '0; e_flush_done = 1'b0;
            e_hit = '0; e_miss = '0;
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) begin
                    m_valid[s][w] = 1'b0;
                    m_use[s][w]   = -w;
                end
        end else begin
            e_rsp_valid  = 1'b0;
            e_flush_done = 1'b0;
            if (m_phase == 0) begin
                if (flush_req) begin
                    for (int s = 0; s < NS; s++)
                        for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
                    e_flush_done = 1'b1;
                end else if (req_valid) begin
                    t_line = req_addr[19:4];
                    t_set  = int'(t_line) % NS;
                    t_hw   = -1;
                    for (int w = 0; w < NW; w++)
                        if (m_valid[t_set][w] && m_line[t_set][w] == t_line) t_hw = w;
                    if (t_hw >= 0) begin
                        e_rsp_valid = 1'b1;
                        e_rsp_data  = m_data[t_set][t_hw];
                        e_rsp_err   = 1'b0;
                        m_stamp++;
                        m_use[t_set][t_hw] = m_stamp;
                        if (e_hit != 16'hFFFF) e_hit++;
                    end else begin
                        m_victim = -1;
                        for (int w = NW - 1; w >= 0; w--)
                            if (!m_valid[t_set][w]) m_victim = w;
                        if (m_victim < 0) begin
                            m_victim = 0;
                            for (int w = 1; w < NW; w++)
                                if (m_use[t_set][w] < m_use[t_set][m_victim]) m_victim = w;
                        end
                        m_mline      = t_line;
                        e_mreq_valid = 1'b1;
                        e_mreq_addr  = t_line;
                        if (e_miss != 16'hFFFF) e_miss++;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (flush_req) m_pend = 1'b1;
                if (mem_req_ready) begin
                    e_mreq_valid = 1'b0;
                    m_phase = 2;
                end
            end else begin
                if (flush_req) m_pend = 1'b1;
                if (mem_rsp_valid) begin
                    e_rsp_valid = 1'b1;
                    e_rsp_data  = mem_rsp_data;
                    e_rsp_err   = mem_rsp_bus_error;
                    t_set = int'(m_mline) % NS;
                    if (!mem_rsp_bus_error) begin
                        m_valid[t_set][m_victim] = 1'b1;
                        m_line[t_set][m_victim]  = m_mline;
                        m_data[t_set][m_victim]  = mem_rsp_data;
                        m_stamp++;
                        m_use[t_set][m_victim] = m_stamp;
                    end
                    if (m_pend) begin
                        for (int s = 0; s < NS; s++)
                            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
                        e_flush_done = 1'b1;
                        m_pend = 1'b0;
                    end
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("req_ready", req_ready, (m_phase == 0) && !flush_req && !m_pend);
            chk("rsp_valid", rsp_valid, e_rsp_valid);
            if (e_rsp_valid) begin
                chk("rsp_data", rsp_data, e_rsp_data);
                chk("rsp_bus_error", rsp_bus_error, e_rsp_err);
            end
            chk("mem_req_valid", mem_req_valid, e_mreq_valid);
            if (e_mreq_valid) chk("mem_req_addr", mem_req_addr, e_mreq_addr);
            chk("flush_done", flush_done, e_flush_done);
            chk("hit_count", hit_count, e_hit);
            chk("miss_count", miss_count, e_miss);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request until accepted; returns just after the accepting edge.
    task automatic access(input logic [19:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) chk("accept timeout", 1'b0, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    // Service one refill: optional ready stall, optional flush pulse while waiting.
    task automatic serve(input logic [127:0] d, input logic err, input int hold, input logic fl);
        int n = 0;
        logic [15:0] a0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_valid) begin
            chk("mem_req timeout", 1'b0, 1'b1);
            return;
        end
        a0 = mem_req_addr;
        for (int i = 0; i < hold; i++) begin
            chk("stall mem_req_valid", mem_req_valid, 1'b1);
            chk("stall mem_req_addr", mem_req_addr, a0);
            chk("stall req_ready", req_ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("mem_req_valid drop", mem_req_valid, 1'b0);
        if (fl) begin
            flush_req = 1'b1;
            tick();
            flush_req = 1'b0;
        end
        tick();
        mem_rsp_valid     = 1'b1;
        mem_rsp_data      = d;
        mem_rsp_bus_error = err;
        tick();
        mem_rsp_valid     = 1'b0;
        mem_rsp_bus_error = 1'b0;
    endtask

    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DA = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0001;
    localparam logic [127:0] DB = 128'hBBBB_0000_BBBB_0000_BBBB_0000_BBBB_0002;
    localparam logic [127:0] DC = 128'hCCCC_0000_CCCC_0000_CCCC_0000_CCCC_0003;
    localparam logic [127:0] DE = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [15:0] miss0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush_req = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_bus_error = 1'b0;
        #2 reset = 1'b0;
        #1 started = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset mem_req_valid", mem_req_valid, 1'b0);
        chk("reset counters", {hit_count, miss_count}, 32'h0);
        chk("reset req_ready", req_ready, 1'b1);

        // Cold miss then hit at 0x00040.
        access(20'h00040);
        chk("cold mem_req_valid", mem_req_valid, 1'b1);
        chk("cold mem_req_addr", mem_req_addr, 16'h0004);
        serve(D1, 1'b0, 0, 1'b0);
        chk("cold rsp_valid", rsp_valid, 1'b1);
        chk("cold rsp_data", rsp_data, D1);
        tick();
        chk("rsp pulse", rsp_valid, 1'b0);
        access(20'h00040);
        chk("hit rsp_valid", rsp_valid, 1'b1);
        chk("hit rsp_data", rsp_data, D1);
        chk("hit_count 1", hit_count, 16'd1);
        chk("miss_count 1", miss_count, 16'd1);

        // Flush in IDLE wins over a same-cycle request.
        flush_req = 1'b1; req_valid = 1'b1; req_addr = 20'h00040;
        #1;
        chk("flush req_ready", req_ready, 1'b0);
        tick();
        flush_req = 1'b0; req_valid = 1'b0;
        chk("idle flush_done", flush_done, 1'b1);
        chk("flush no accept", {rsp_valid, mem_req_valid}, 2'b00);
        chk("flush keeps hit_count", hit_count, 16'd1);

        // LRU in set 0: A, B, hit A, C evicts B; A still hits, B misses.
        access(20'h00000); serve(DA, 1'b0, 0, 1'b0);
        access(20'h00040); serve(DB, 1'b0, 0, 1'b0);
        access(20'h00000);
        chk("lru hit A", {rsp_valid, rsp_data}, {1'b1, DA});
        access(20'h00080);
        chk("lru C miss", mem_req_valid, 1'b1);
        serve(DC, 1'b0, 0, 1'b0);
        access(20'h00000);
        chk("lru A survives", {rsp_valid, rsp_data}, {1'b1, DA});
        access(20'h00040);
        chk("lru B evicted", {rsp_valid, mem_req_valid, mem_req_addr}, {1'b0, 1'b1, 16'h0004});
        serve(DB, 1'b0, 0, 1'b0);

        // Bus error: no allocation, so the retry misses again.
        miss0 = miss_count;
        access(20'h00100); serve(DE, 1'b1, 0, 1'b0);
        chk("err rsp", {rsp_valid, rsp_bus_error}, 2'b11);
        access(20'h00100);
        chk("err retry miss", mem_req_valid, 1'b1);
        chk("err miss delta", miss_count - miss0, 16'd2);
        serve(DA, 1'b0, 0, 1'b0);

        // Refill request stalled five cycles.
        access(20'h00200);
        chk("stall addr", mem_req_addr, 16'h0020);
        serve(DC, 1'b0, 5, 1'b0);
        access(20'h00200);
        chk("stalled line hits", {rsp_valid, rsp_data}, {1'b1, DC});

        // Flush during MISS_WAIT: applied on return, cached line then misses.
        access(20'h00300);
        serve(DB, 1'b0, 0, 1'b1);
        chk("wait flush rsp", {rsp_valid, flush_done}, 2'b11);
        tick();
        chk("flush_done pulse", flush_done, 1'b0);
        access(20'h00200);
        chk("after flush miss", {rsp_valid, mem_req_valid}, 2'b01);
        serve(DA, 1'b0, 0, 1'b0);
        access(20'h00300);
        chk("filled line flushed", mem_req_valid, 1'b1);
        serve(DB, 1'b0, 0, 1'b0);

        // Reset in MISS_WAIT drops the transaction.
        access(20'h00400);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst outputs", {rsp_valid, rsp_bus_error, mem_req_valid, flush_done}, 4'b0000);
        chk("rst data/addr", {rsp_data, mem_req_addr}, 144'h0);
        chk("rst counters", {hit_count, miss_count}, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = DE;
        tick();
        mem_rsp_valid = 1'b0;
        chk("late rsp ignored", rsp_valid, 1'b0);
        tick();
        chk("late rsp counters", {hit_count, miss_count, rsp_valid}, 33'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
